// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide_add_seq sequencer: the FSM state
// encoding and the word width of the shared adder.
package wide_add_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_adder_32b.sv
// adder_32b: combinational 32-bit adder with carry in and carry out.
// Ports:
//   a, b  in  32  addends
//   cin   in  1   carry into bit 0
//   sum   out 32  a + b + cin (low 32 bits)
//   cout  out 1   carry out of bit 31
module adder_32b
    import wide_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W:0] full;

    // One 33-bit add; the top bit is the carry out.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
        sum  = full[WORD_W-1:0];
        cout = full[WORD_W];
    end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-precision add/subtract that walks one shared 32-bit
// adder over WORDS words, least-significant word first, one word per clock.
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous active-high reset
//   start  in   1          request, honoured only in IDLE or DONE
//   sub    in   1          0: a + b + cin, 1: a - b (cin ignored)
//   a, b   in   32*WORDS   operands, latched with start
//   cin    in   1          carry into word 0 when sub = 0
//   busy   out  1          high while words are being processed
//   done   out  1          one-cycle result-valid pulse
//   sum    out  32*WORDS   registered result
//   cout   out  1          carry out of the top word (sub: 1 = no borrow)
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    cout
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            state;
    state_t            state_next;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              sub_reg;
    logic              carry_reg;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              last_word;
    logic [31:0]       word_base;
    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    // Select the current operand words; subtraction adds the one's
    // complement of b, with the +1 supplied by the initial carry.
    always_comb begin
        word_base = 32'(idx) * 32'(WORD_W);
        add_a     = a_reg[word_base +: WORD_W];
        if (sub_reg) begin
            add_b = ~b_reg[word_base +: WORD_W];
        end else begin
            add_b = b_reg[word_base +: WORD_W];
        end
    end

    adder_32b u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state logic and start acceptance.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_word  = (idx == LAST_IDX);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus busy/done flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Operand latch and word-serial datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub;
            carry_reg <= sub ? 1'b1 : cin;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (state == RUN) begin
            sum[word_base +: WORD_W] <= add_sum;
            carry_reg                <= add_cout;
            if (last_word) begin
                // Final carry is exposed together with the completed sum.
                cout <= add_cout;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq with WORDS = 4: a whole-width
// arithmetic model checked every cycle, plus directed literal checks.
module tb_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model state: m_cnt = cycles since the accepting edge (0 = idle)
    int           m_cnt  = 0;
    logic [W:0]   m_res  = '0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s, input logic c);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model of result timing and values
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if ((m_cnt == 0 || m_cnt == WORDS + 1) && start) begin
            m_res  <= model_result(a, b, sub, cin);
            m_cnt  <= 1;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_cnt >= 1 && m_cnt <= WORDS) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == WORDS) begin
                m_sum  <= m_res[W-1:0];
                m_cout <= m_res[W];
            end
        end else begin
            m_cnt <= 0;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, (m_cnt >= 1 && m_cnt <= WORDS)});
            check("done", {{(W-1){1'b0}}, done}, {{(W-1){1'b0}}, (m_cnt == WORDS + 1)});
            if (!(m_cnt >= 1 && m_cnt <= WORDS)) begin
                check("sum_model", sum, m_sum);
                check("cout_model", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, m_cout});
            end
        end
    end

    // drive operands and a one-cycle start; returns in the first RUN cycle
    task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, input logic xc);
        @(negedge clk);
        a     = xa;
        b     = xb;
        sub   = xs;
        cin   = xc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // wait (bounded) for done; n0 is the cycle number after acceptance now
    task automatic wait_done(input int n0, output int lat, output int nbusy);
        int n;
        n     = n0;
        nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        lat = n;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        int dcnt;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
        check("rst_done", {{(W-1){1'b0}}, done}, '0);
        check("rst_sum", sum, '0);
        check("rst_cout", {{(W-1){1'b0}}, cout}, '0);

        // 1. zero
        launch('0, '0, 1'b0, 1'b0);
        wait_done(1, lat, nb);
        check("zero_latency", W'(lat), W'(5));
        check("zero_busy_cycles", W'(nb), W'(4));
        check("zero_sum", sum, '0);
        check("zero_cout", {{(W-1){1'b0}}, cout}, '0);

        // 2. inter-word carry
        launch(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0);
        wait_done(1, lat, nb);
        check("carry_sum", sum, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
        check("carry_cout", {{(W-1){1'b0}}, cout}, '0);

        // 3. full ripple with cin
        launch({W{1'b1}}, '0, 1'b0, 1'b1);
        wait_done(1, lat, nb);
        check("ripple_sum", sum, '0);
        check("ripple_cout", {{(W-1){1'b0}}, cout}, 128'h1);

        // 4. subtraction, cin held at 1
        launch(128'd7, 128'd5, 1'b1, 1'b1);
        wait_done(1, lat, nb);
        check("sub_pos_sum", sum, 128'd2);
        check("sub_pos_cout", {{(W-1){1'b0}}, cout}, 128'h1);
        launch(128'd5, 128'd7, 1'b1, 1'b1);
        wait_done(1, lat, nb);
        check("sub_neg_sum", sum, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        check("sub_neg_cout", {{(W-1){1'b0}}, cout}, '0);

        // 5a. start during RUN is ignored
        launch(128'h1234, 128'h1111, 1'b0, 1'b0);
        @(negedge clk);
        a     = 128'hDEAD_0000;
        b     = 128'h0000_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat, nb);
        check("ignore_latency", W'(lat), W'(5));
        check("ignore_sum", sum, 128'h2345);
        @(negedge clk);
        check("ignore_no_restart", {{(W-1){1'b0}}, busy}, '0);

        // 5b. reset in the 3rd RUN cycle
        launch(128'h5, 128'h6, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {{(W-1){1'b0}}, busy}, '0);
        check("abort_done", {{(W-1){1'b0}}, done}, '0);
        check("abort_sum", sum, '0);
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", W'(dcnt), '0);

        // 6. back-to-back with start held across DONE
        launch(128'h100, 128'h23, 1'b0, 1'b0);
        wait_done(1, lat, nb);
        check("b2b_first_sum", sum, 128'h123);
        a     = 128'd1;
        b     = 128'd2;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart_busy", {{(W-1){1'b0}}, busy}, 128'h1);
        check("b2b_restart_done", {{(W-1){1'b0}}, done}, '0);
        wait_done(1, lat, nb);
        check("b2b_latency", W'(lat), W'(5));
        check("b2b_second_sum", sum, 128'd3);
        check("b2b_second_cout", {{(W-1){1'b0}}, cout}, '0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
